// File: rtl/batcharger_ctrl.sv
// rtl/batcharger_ctrl.sv - TC/CC/CV battery charge sequencer with registered Moore outputs
module batcharger_ctrl #(
    parameter logic [7:0]  VCUTOFF  = 8'd170,
    parameter logic [7:0]  VPRESET  = 8'd209,
    parameter logic [7:0]  VRESTART = 8'd200,
    parameter logic [7:0]  ITERM    = 8'd6,
    parameter logic [7:0]  TLO      = 8'd40,
    parameter logic [7:0]  THI      = 8'd200,
    parameter logic [15:0] TMAX     = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sel,
    input  logic       smp_valid,
    input  logic [7:0] vbat_code,
    input  logic [7:0] ibat_code,
    input  logic [7:0] vtemp_code,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic [7:0] iset,
    output logic [7:0] vset,
    output logic       chg_done,
    output logic       temp_fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TC   = 3'd1,
        S_CC   = 3'd2,
        S_CV   = 3'd3,
        S_DONE = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    state_t      cur, nxt;
    logic [3:0]  sel_q, sel_n;
    logic [15:0] cv_cnt, cnt_n;
    logic [16:0] cnt_inc;
    logic        tok;
    logic [7:0]  itc, icc;

    always_comb begin
        tok     = (vtemp_code >= TLO) && (vtemp_code <= THI);
        cnt_inc = {1'b0, cv_cnt} + 17'd1;
        nxt     = cur;
        sel_n   = sel_q;
        cnt_n   = cv_cnt;
        if (!en) begin
            nxt = S_IDLE;
        end else if (smp_valid) begin
            case (cur)
                S_IDLE: begin
                    sel_n = sel;
                    if (!tok)                  nxt = S_HOLD;
                    else if (vbat_code < VCUTOFF) nxt = S_TC;
                    else if (vbat_code < VPRESET) nxt = S_CC;
                    else begin
                        nxt   = S_CV;
                        cnt_n = 16'd0;
                    end
                end
                S_TC: begin
                    if (!tok)                      nxt = S_HOLD;
                    else if (vbat_code >= VCUTOFF) nxt = S_CC;
                end
                S_CC: begin
                    if (!tok) nxt = S_HOLD;
                    else if (vbat_code >= VPRESET) begin
                        nxt   = S_CV;
                        cnt_n = 16'd0;
                    end
                end
                S_CV: begin
                    cnt_n = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
                    // Temperature outranks termination when both hit on one sample
                    if (!tok) nxt = S_HOLD;
                    else if ((ibat_code <= ITERM) || (cnt_inc >= {1'b0, TMAX})) nxt = S_DONE;
                end
                S_DONE: begin
                    if (vbat_code < VRESTART) nxt = S_IDLE;
                end
                S_HOLD: begin
                    if (tok) nxt = S_IDLE;
                end
                default: nxt = S_IDLE;
            endcase
        end
        // Outputs follow the next state so they register together with it
        itc = {4'd0, sel_n} + 8'd1;
        icc = itc << 3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= S_IDLE;
            sel_q      <= 4'd0;
            cv_cnt     <= 16'd0;
            tc         <= 1'b0;
            cc         <= 1'b0;
            cv         <= 1'b0;
            iset       <= 8'd0;
            vset       <= 8'd0;
            chg_done   <= 1'b0;
            temp_fault <= 1'b0;
        end else begin
            cur        <= nxt;
            sel_q      <= sel_n;
            cv_cnt     <= cnt_n;
            tc         <= (nxt == S_TC);
            cc         <= (nxt == S_CC);
            cv         <= (nxt == S_CV);
            chg_done   <= (nxt == S_DONE);
            temp_fault <= (nxt == S_HOLD);
            case (nxt)
                S_TC:    iset <= itc;
                S_CC:    iset <= icc;
                S_CV:    iset <= icc;
                default: iset <= 8'd0;
            endcase
            vset <= (nxt == S_CV) ? VPRESET : 8'd0;
        end
    end

    assign state = cur;

endmodule

// File: doc/batcharger_ctrl.md
# batcharger_ctrl

Digital charge controller for the 64-bit real-valued battery charger macro. It consumes periodic ADC samples of battery voltage, current and temperature, and runs the trickle/constant-current/constant-voltage (TC/CC/CV) charge sequence. It drives the one-hot mode flags and the current/voltage set-point codes that the analog charger front-end converts into `iforcedbat`. It is the decision-making side of the mode flags that the charger bench monitors (`tc`, `cc`, `cv`).

## Interface
Parameters:
- `VCUTOFF`, 8'd170: vbat code below which TC is used.
- `VPRESET`, 8'd209: CV target code; CC→CV threshold.
- `VRESTART`, 8'd200: in DONE, vbat below this restarts charging.
- `ITERM`, 8'd6: ibat code at or below which CV terminates.
- `TLO`, 8'd40: lower bound of the valid temperature window, inclusive.
- `THI`, 8'd200: upper bound of the valid temperature window, inclusive.
- `TMAX`, 16'd1000: maximum number of CV samples before forced termination.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: block enable.
- `sel`, in, 4: capacity select; capacity = (sel+1)×50 mAh.
- `smp_valid`, in, 1: one-cycle pulse qualifying the sample inputs.
- `vbat_code`, in, 8: battery voltage ADC code.
- `ibat_code`, in, 8: battery current ADC code.
- `vtemp_code`, in, 8: temperature ADC code.
- `tc`, out, 1: trickle-current mode flag.
- `cc`, out, 1: constant-current mode flag.
- `cv`, out, 1: constant-voltage mode flag.
- `iset`, out, 8: current DAC code.
- `vset`, out, 8: voltage DAC code.
- `chg_done`, out, 1: high while in DONE.
- `temp_fault`, out, 1: high while in HOLD.
- `state`, out, 3: encoded FSM state.

## Operation
- State encoding: IDLE=0, TC=1, CC=2, CV=3, DONE=4, HOLD=5.
- Temperature check: `tok` = (TLO ≤ vtemp_code ≤ THI).
- Set-point arithmetic:
  - On the IDLE exit, `sel` is latched into `sel_q`; later changes to `sel` are ignored until the FSM returns to IDLE.
  - `icc` = (sel_q+1)<<3, range 8..128.
  - `itc` = sel_q+1.
  - All arithmetic is unsigned and 8-bit; no overflow is possible.
- Transitions are evaluated only on cycles with `smp_valid`=1, with one exception: `en`=0 forces IDLE on every cycle.
- Priority, highest first: `en`=0, then `!tok` (TC/CC/CV go to HOLD), then the normal transitions below.
- Normal transitions:
  - IDLE (en=1, tok): vbat<VCUTOFF → TC; else vbat<VPRESET → CC; else → CV.
  - IDLE (en=1, !tok) → HOLD.
  - TC: vbat ≥ VCUTOFF → CC.
  - CC: vbat ≥ VPRESET → CV; on entry `cv_cnt` is cleared to 0.
  - CV: increments `cv_cnt` (16-bit, saturating) on each valid sample. Goes to DONE when ibat ≤ ITERM, or when cv_cnt+1 ≥ TMAX.
  - DONE: vbat < VRESTART → IDLE. Temperature is ignored in DONE.
  - HOLD: tok → IDLE. Re-entry then re-evaluates from IDLE on the next valid sample.
- Outputs (Moore, registered):
  - IDLE, HOLD, DONE: all three flags 0; iset=0; vset=0.
  - TC: tc=1; iset=itc; vset=0.
  - CC: cc=1; iset=icc; vset=0.
  - CV: cv=1; iset=icc (current limit); vset=VPRESET.
- Invariant: {cv,cc,tc} is always one-hot or all-zero.

## Timing
- On reset: state=IDLE; every output 0; `cv_cnt`=0; `sel_q`=0. Asserting reset mid-charge clears everything immediately, asynchronously.
- Latency: a sample accepted at rising edge k produces the new state and outputs at edge k; they are visible for the following cycle. There is exactly one transition per sample.
- `en` deassertion takes effect at the next edge, regardless of `smp_valid`.
- Samples with `smp_valid`=0 are ignored; input values are don't-care.
- Back-to-back valid pulses are legal. The IDLE→TC→CC chain needs one sample per hop; there is no skipping except at IDLE entry.
- In CV, a sample that satisfies both ibat ≤ ITERM and !tok goes to HOLD, because temperature has priority.

## Test plan
- **Reset/idle:** rst=1, then release with en=0 → state=0, all outputs 0 for 100 cycles, including while valid samples arrive.
- **Full charge, sel=4'b1000:**
  - Sample vbat=100, temp=100 → tc=1, iset=9.
  - vbat=180 → cc=1, iset=72.
  - vbat=210 → cv=1, vset=209.
  - ibat=5 → chg_done=1, iset=0.
  - vbat=190 → IDLE.
- **Temperature fault:** in CC, sample temp=220 → temp_fault=1, flags 0. Then temp=100 → IDLE; next sample vbat=180 → CC.
- **CV timeout with TMAX=16'd4:** enter CV, then hold ibat=50. DONE asserts exactly on the 4th valid CV sample.
- **Async events:** drop en in CV between samples → IDLE at the next edge. Pulse rst mid-CC → outputs 0 asynchronously. Change sel in CC → iset unchanged.
- **Boundaries:** vbat=170 in IDLE → CC, not TC. temp=40 and temp=200 → accepted. temp=39 → HOLD.
